// File: rtl/i2c_app_pkg.sv
// Shared definitions for the I2C sensor responder: register map, constants,
// FSM state encoding and a byte-select helper.
package i2c_app_pkg;

  localparam logic [7:0] ADDR_X_H      = 8'h3B;
  localparam logic [7:0] ADDR_X_L      = 8'h3C;
  localparam logic [7:0] ADDR_Y_H      = 8'h3D;
  localparam logic [7:0] ADDR_Y_L      = 8'h3E;
  localparam logic [7:0] ADDR_Z_H      = 8'h3F;
  localparam logic [7:0] ADDR_Z_L      = 8'h40;
  localparam logic [7:0] ADDR_PWR_MGMT = 8'h6B;
  localparam logic [7:0] ADDR_WHO_AM_I = 8'h75;

  localparam logic [7:0] WHO_AM_I_VAL  = 8'h68;
  localparam logic [7:0] PWR_MGMT_RST  = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_PTR = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_RD_DATA = 2'd3
  } state_e;

  function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
    logic [7:0] res;
    if (hi) begin
      res = word[15:8];
    end else begin
      res = word[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sensor_snapshot.sv
// Sensor sample staging and read-coherent shadow: the shadow stays frozen while
// a read transaction is active and catches up as soon as it ends.
module sensor_snapshot (
  input  logic        app_clk,
  input  logic        arstn,
  input  logic        sample_stb,
  input  logic        in_read,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic [15:0] shadow_x,
  output logic [15:0] shadow_y,
  output logic [15:0] shadow_z
);

  logic [15:0] stage_x_r, stage_y_r, stage_z_r;
  logic [15:0] shadow_x_r, shadow_y_r, shadow_z_r;
  logic        pending_r;

  // Staging always tracks the latest strobed samples.
  always_ff @(posedge app_clk or negedge arstn) begin
    if (!arstn) begin
      stage_x_r <= 16'h0000;
      stage_y_r <= 16'h0000;
      stage_z_r <= 16'h0000;
    end else if (sample_stb) begin
      stage_x_r <= sample_x;
      stage_y_r <= sample_y;
      stage_z_r <= sample_z;
    end
  end

  // Shadow update: direct outside a read, deferred via pending during one.
  always_ff @(posedge app_clk or negedge arstn) begin
    if (!arstn) begin
      shadow_x_r <= 16'h0000;
      shadow_y_r <= 16'h0000;
      shadow_z_r <= 16'h0000;
      pending_r  <= 1'b0;
    end else if (sample_stb && !in_read) begin
      shadow_x_r <= sample_x;
      shadow_y_r <= sample_y;
      shadow_z_r <= sample_z;
      pending_r  <= 1'b0;
    end else if (sample_stb && in_read) begin
      pending_r  <= 1'b1;
    end else if (pending_r && !in_read) begin
      shadow_x_r <= stage_x_r;
      shadow_y_r <= stage_y_r;
      shadow_z_r <= stage_z_r;
      pending_r  <= 1'b0;
    end
  end

  assign shadow_x = shadow_x_r;
  assign shadow_y = shadow_y_r;
  assign shadow_z = shadow_z_r;

endmodule

// File: rtl/i2c_sensor_responder.sv
// Application-side I2C register responder for a 3-axis sensor: pointer-based
// register map with PWR_MGMT, WHO_AM_I and coherent burst reads of samples.
module i2c_sensor_responder
  import i2c_app_pkg::*;
(
  input  logic        app_clk,
  input  logic        arstn,
  input  logic        hdr_valid,
  input  logic        hdr_rw,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_req,
  input  logic        master_nack,
  input  logic        stop_det,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_stb,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        rx_ack,
  output logic        rx_ack_valid,
  output logic        busy,
  output logic [7:0]  pwr_reg,
  output logic        wr_err
);

  state_e      state_r, state_s;
  logic [7:0]  ptr_r, ptr_s;
  logic [7:0]  pwr_reg_r, pwr_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        tx_valid_r, tx_valid_s;
  logic        rx_ack_r, rx_ack_s;
  logic        rx_ack_valid_r, rx_ack_valid_s;
  logic        wr_err_r, wr_err_s;
  logic        busy_r;
  logic [7:0]  rd_byte_s;
  logic [15:0] shadow_x_s, shadow_y_s, shadow_z_s;

  sensor_snapshot u_snapshot (
    .app_clk    (app_clk),
    .arstn      (arstn),
    .sample_stb (sample_stb),
    .in_read    (state_r == ST_RD_DATA),
    .sample_x   (sample_x),
    .sample_y   (sample_y),
    .sample_z   (sample_z),
    .shadow_x   (shadow_x_s),
    .shadow_y   (shadow_y_s),
    .shadow_z   (shadow_z_s)
  );

  // Register map read decode at the current pointer.
  always_comb begin
    rd_byte_s = 8'h00;
    case (ptr_r)
      ADDR_X_H:      rd_byte_s = sel_byte(shadow_x_s, 1'b1);
      ADDR_X_L:      rd_byte_s = sel_byte(shadow_x_s, 1'b0);
      ADDR_Y_H:      rd_byte_s = sel_byte(shadow_y_s, 1'b1);
      ADDR_Y_L:      rd_byte_s = sel_byte(shadow_y_s, 1'b0);
      ADDR_Z_H:      rd_byte_s = sel_byte(shadow_z_s, 1'b1);
      ADDR_Z_L:      rd_byte_s = sel_byte(shadow_z_s, 1'b0);
      ADDR_PWR_MGMT: rd_byte_s = pwr_reg_r;
      ADDR_WHO_AM_I: rd_byte_s = WHO_AM_I_VAL;
      default:       rd_byte_s = 8'h00;
    endcase
  end

  // Next-state and next-output logic; a header always wins, STOP is applied
  // after the current byte has been handled.
  always_comb begin
    state_s        = state_r;
    ptr_s          = ptr_r;
    pwr_s          = pwr_reg_r;
    tx_data_s      = tx_data_r;
    tx_valid_s     = 1'b0;
    rx_ack_s       = rx_ack_r;
    rx_ack_valid_s = 1'b0;
    wr_err_s       = 1'b0;
    if (hdr_valid) begin
      state_s = hdr_rw ? ST_RD_DATA : ST_GET_PTR;
    end else begin
      case (state_r)
        ST_GET_PTR: begin
          if (rx_valid) begin
            ptr_s          = rx_data;
            rx_ack_s       = 1'b1;
            rx_ack_valid_s = 1'b1;
            state_s        = ST_WR_DATA;
          end else begin
            state_s = ST_GET_PTR;
          end
        end
        ST_WR_DATA: begin
          if (rx_valid) begin
            rx_ack_valid_s = 1'b1;
            ptr_s          = ptr_r + 8'd1;
            if (ptr_r == ADDR_PWR_MGMT) begin
              pwr_s    = rx_data;
              rx_ack_s = 1'b1;
            end else begin
              rx_ack_s = 1'b0;
              wr_err_s = 1'b1;
            end
          end else begin
            state_s = ST_WR_DATA;
          end
        end
        ST_RD_DATA: begin
          // A master NACK only ends the burst on the bus; keep serving requests.
          if (tx_req) begin
            tx_data_s  = rd_byte_s;
            tx_valid_s = 1'b1;
            ptr_s      = ptr_r + 8'd1;
          end else if (master_nack) begin
            ptr_s = ptr_r;
          end else begin
            state_s = ST_RD_DATA;
          end
        end
        default: state_s = ST_IDLE;
      endcase
      if (stop_det) begin
        state_s = ST_IDLE;
      end else begin
        state_s = state_s;
      end
    end
  end

  // State, pointer and registered outputs.
  always_ff @(posedge app_clk or negedge arstn) begin
    if (!arstn) begin
      state_r        <= ST_IDLE;
      ptr_r          <= 8'h00;
      pwr_reg_r      <= PWR_MGMT_RST;
      tx_data_r      <= 8'h00;
      tx_valid_r     <= 1'b0;
      rx_ack_r       <= 1'b0;
      rx_ack_valid_r <= 1'b0;
      wr_err_r       <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      ptr_r          <= ptr_s;
      pwr_reg_r      <= pwr_s;
      tx_data_r      <= tx_data_s;
      tx_valid_r     <= tx_valid_s;
      rx_ack_r       <= rx_ack_s;
      rx_ack_valid_r <= rx_ack_valid_s;
      wr_err_r       <= wr_err_s;
      busy_r         <= (state_s != ST_IDLE);
    end
  end

  assign tx_data      = tx_data_r;
  assign tx_valid     = tx_valid_r;
  assign rx_ack       = rx_ack_r;
  assign rx_ack_valid = rx_ack_valid_r;
  assign wr_err       = wr_err_r;
  assign busy         = busy_r;
  assign pwr_reg      = pwr_reg_r;

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Self-checking bench for i2c_sensor_responder: directed scenarios plus random
// transactions against a transaction-level register-map model.
module tb_i2c_sensor_responder;

  logic        app_clk = 1'b0;
  logic        arstn;
  logic        hdr_valid, hdr_rw, rx_valid, tx_req, master_nack, stop_det, sample_stb;
  logic [7:0]  rx_data;
  logic [15:0] sample_x, sample_y, sample_z;
  logic [7:0]  tx_data, pwr_reg;
  logic        tx_valid, rx_ack, rx_ack_valid, busy, wr_err;

  int errors = 0;
  int checks = 0;

  // Model: transaction phase 0 idle, 1 pointer byte next, 2 data bytes, 3 reading.
  int         m_phase;
  logic [7:0] m_ptr, m_pwr;
  logic [15:0] m_sh [3];
  logic [15:0] m_st [3];
  bit         m_pend;

  i2c_sensor_responder dut (
    .app_clk(app_clk), .arstn(arstn), .hdr_valid(hdr_valid), .hdr_rw(hdr_rw),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req), .master_nack(master_nack),
    .stop_det(stop_det), .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_stb(sample_stb), .tx_data(tx_data), .tx_valid(tx_valid), .rx_ack(rx_ack),
    .rx_ack_valid(rx_ack_valid), .busy(busy), .pwr_reg(pwr_reg), .wr_err(wr_err)
  );

  always #5 app_clk = ~app_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  function automatic logic [7:0] ref_byte(input logic [7:0] a);
    logic [7:0] r;
    if (a >= 8'h3B && a <= 8'h40) begin
      r = (((a - 8'h3B) % 2) == 0) ? m_sh[(a - 8'h3B) / 2][15:8] : m_sh[(a - 8'h3B) / 2][7:0];
    end else if (a == 8'h6B) begin
      r = m_pwr;
    end else if (a == 8'h75) begin
      r = 8'h68;
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_ptr = 8'h00; m_pwr = 8'h40; m_pend = 1'b0;
    for (int i = 0; i < 3; i++) begin m_sh[i] = 16'h0; m_st[i] = 16'h0; end
  endfunction

  function automatic void model_end_read();
    if (m_phase == 3 && m_pend) begin
      for (int i = 0; i < 3; i++) m_sh[i] = m_st[i];
      m_pend = 1'b0;
    end
  endfunction

  task automatic do_hdr(input bit rw, input bit with_stop);
    hdr_valid = 1'b1; hdr_rw = rw; stop_det = with_stop;
    tick();
    hdr_valid = 1'b0; stop_det = 1'b0;
    if (rw) m_phase = 3;
    else begin model_end_read(); m_phase = 1; end
    check("hdr_busy", busy, 16'd1);
  endtask

  task automatic do_stop();
    stop_det = 1'b1;
    tick();
    stop_det = 1'b0;
    model_end_read(); m_phase = 0;
    check("stop_busy", busy, 16'd0);
  endtask

  task automatic do_stb(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_stb = 1'b1; sample_x = x; sample_y = y; sample_z = z;
    tick();
    sample_stb = 1'b0;
    m_st[0] = x; m_st[1] = y; m_st[2] = z;
    if (m_phase == 3) m_pend = 1'b1;
    else begin m_sh[0] = x; m_sh[1] = y; m_sh[2] = z; end
  endtask

  task automatic do_rx(input logic [7:0] d, input bit with_stop);
    bit exp_v, exp_ack, exp_err;
    rx_valid = 1'b1; rx_data = d; stop_det = with_stop;
    tick();
    rx_valid = 1'b0; stop_det = 1'b0;
    exp_v = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    if (m_phase == 1) begin
      exp_v = 1'b1; exp_ack = 1'b1; m_ptr = d; m_phase = 2;
    end else if (m_phase == 2) begin
      exp_v = 1'b1; exp_ack = (m_ptr == 8'h6B); exp_err = !exp_ack;
      if (exp_ack) m_pwr = d;
      m_ptr = m_ptr + 8'd1;
    end
    if (with_stop) m_phase = 0;
    check("rx_ack_valid", rx_ack_valid, exp_v);
    if (exp_v) check("rx_ack", rx_ack, exp_ack);
    check("wr_err", wr_err, exp_err);
    check("pwr_reg", pwr_reg, m_pwr);
    check("ptr_after_rx", dut.ptr_r, m_ptr);
    check("busy_after_rx", busy, (m_phase != 0));
    tick();
    check("rx_ack_valid_pulse", rx_ack_valid, 16'd0);
    check("wr_err_pulse", wr_err, 16'd0);
  endtask

  task automatic do_tx(input bit with_stop);
    bit exp_v;
    logic [7:0] exp_d;
    tx_req = 1'b1; stop_det = with_stop;
    tick();
    tx_req = 1'b0; stop_det = 1'b0;
    exp_v = (m_phase == 3);
    exp_d = ref_byte(m_ptr);
    if (exp_v) m_ptr = m_ptr + 8'd1;
    if (with_stop) begin model_end_read(); m_phase = 0; end
    check("tx_valid", tx_valid, exp_v);
    if (exp_v) check("tx_data", tx_data, exp_d);
    check("ptr_after_tx", dut.ptr_r, m_ptr);
    tick();
    check("tx_valid_pulse", tx_valid, 16'd0);
  endtask

  task automatic do_nack();
    master_nack = 1'b1;
    tick();
    master_nack = 1'b0;
    check("nack_ptr", dut.ptr_r, m_ptr);
    check("nack_busy", busy, 16'd1);
  endtask

  function automatic logic [7:0] pick_ptr();
    logic [7:0] p;
    case ($urandom_range(0, 4))
      0: p = 8'h3B + 8'($urandom_range(0, 5));
      1: p = 8'h6B;
      2: p = 8'h75;
      3: p = 8'hFF;
      default: p = 8'($urandom_range(0, 255));
    endcase
    return p;
  endfunction

  initial begin
    arstn = 1'b0; hdr_valid = 1'b0; hdr_rw = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tx_req = 1'b0; master_nack = 1'b0; stop_det = 1'b0; sample_stb = 1'b0;
    sample_x = 16'h0; sample_y = 16'h0; sample_z = 16'h0;
    model_reset();
    tick(); tick();
    check("rst_busy", busy, 16'd0);
    check("rst_tx_valid", tx_valid, 16'd0);
    check("rst_tx_data", tx_data, 16'd0);
    check("rst_rx_ack", rx_ack, 16'd0);
    check("rst_rx_ack_valid", rx_ack_valid, 16'd0);
    check("rst_wr_err", wr_err, 16'd0);
    check("rst_pwr_reg", pwr_reg, 16'h40);
    arstn = 1'b1;
    tick();
    check("post_rst_tx_valid", tx_valid, 16'd0);
    check("post_rst_ptr", dut.ptr_r, 16'h00);

    // Burst read of all six sample bytes.
    do_stb(16'h1234, 16'hABCD, 16'h0F0F);
    do_hdr(1'b0, 1'b0); do_rx(8'h3B, 1'b0); do_hdr(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) do_tx(1'b0);
    check("burst_final_ptr", dut.ptr_r, 16'h41);
    do_stop();

    // PWR_MGMT write.
    do_hdr(1'b0, 1'b0); do_rx(8'h6B, 1'b0); do_rx(8'h00, 1'b0);
    check("pwr_written", pwr_reg, 16'h00);
    check("pwr_ptr", dut.ptr_r, 16'h6C);
    do_stop();

    // Write to read-only WHO_AM_I, then read it back.
    do_hdr(1'b0, 1'b0); do_rx(8'h75, 1'b0); do_rx(8'h55, 1'b0); do_stop();
    do_hdr(1'b0, 1'b0); do_rx(8'h75, 1'b0); do_hdr(1'b1, 1'b0); do_tx(1'b0); do_stop();

    // Sample arriving mid-read must not tear X_H/X_L.
    do_hdr(1'b0, 1'b0); do_rx(8'h3B, 1'b0); do_hdr(1'b1, 1'b0); do_tx(1'b0);
    do_stb(16'h1111, 16'h2222, 16'h3333);
    do_tx(1'b0); do_stop();
    do_hdr(1'b0, 1'b0); do_rx(8'h3B, 1'b0); do_hdr(1'b1, 1'b0); do_tx(1'b0); do_tx(1'b0); do_stop();

    // Pointer wrap.
    do_hdr(1'b0, 1'b0); do_rx(8'hFF, 1'b0); do_hdr(1'b1, 1'b0); do_tx(1'b0); do_tx(1'b0);
    check("wrap_ptr", dut.ptr_r, 16'h01);
    do_stop();

    // rx in IDLE and RD_DATA ignored; NACK keeps serving.
    do_rx(8'hA5, 1'b0);
    do_hdr(1'b1, 1'b0); do_rx(8'h5A, 1'b0); do_tx(1'b0); do_nack(); do_tx(1'b0); do_stop();

    // Simultaneous events.
    do_hdr(1'b0, 1'b0); do_rx(8'h6B, 1'b0); do_rx(8'h77, 1'b1);
    do_hdr(1'b0, 1'b1); do_rx(8'h6B, 1'b0); do_hdr(1'b1, 1'b0); do_tx(1'b1);
    do_rx(8'h11, 1'b0);

    // Random transactions.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: do_stb(16'($urandom), 16'($urandom), 16'($urandom));
        1: begin
          do_hdr(1'b0, 1'b0); do_rx(pick_ptr(), 1'b0);
          for (int k = 0; k < int'($urandom_range(0, 2)); k++) do_rx(8'($urandom), 1'b0);
          do_stop();
        end
        2: begin
          do_hdr(1'b0, 1'b0); do_rx(pick_ptr(), 1'b0); do_hdr(1'b1, 1'b0);
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
            if ($urandom_range(0, 2) == 0) do_stb(16'($urandom), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) do_nack();
            do_tx(1'b0);
          end
          do_stop();
        end
        default: begin
          do_hdr(1'b1, 1'b0); do_tx(1'b0); do_tx(1'b1);
        end
      endcase
    end

    // Reset in the middle of a read.
    do_hdr(1'b0, 1'b0); do_rx(8'h6B, 1'b0); do_rx(8'h12, 1'b0);
    do_hdr(1'b1, 1'b0);
    tx_req = 1'b1; arstn = 1'b0;
    model_reset();
    tick();
    check("mid_rst_busy", busy, 16'd0);
    check("mid_rst_tx_valid", tx_valid, 16'd0);
    check("mid_rst_pwr", pwr_reg, 16'h40);
    check("mid_rst_ptr", dut.ptr_r, 16'h00);
    tx_req = 1'b0; arstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rel_tx_valid", tx_valid, 16'd0);
      check("rel_rx_ack_valid", rx_ack_valid, 16'd0);
      check("rel_busy", busy, 16'd0);
    end
    do_hdr(1'b0, 1'b0); do_rx(8'h3B, 1'b0); do_hdr(1'b1, 1'b0); do_tx(1'b0); do_stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_sensor_responder.md
I2C_SENSOR_RESPONDER -- requirements
Module: i2c_sensor_responder

Interface
REQ-001 SHALL have port app_clk  in  1  application clock; all logic rising-edge.
REQ-002 SHALL have port arstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port hdr_valid  in  1  one-cycle pulse: the slave PHY matched device address 0x68 after a START or repeated START.
REQ-004 SHALL have port hdr_rw  in  1  R/W bit qualified by hdr_valid (1 = read).
REQ-005 SHALL have port rx_valid  in  1  one-cycle pulse: a write byte was received.
REQ-006 SHALL have port rx_data  in  8  received byte, qualified by rx_valid.
REQ-007 SHALL have port tx_req  in  1  one-cycle pulse: the PHY needs the next read byte.
REQ-008 SHALL have port master_nack  in  1  one-cycle pulse: the master NACKed the last read byte.
REQ-009 SHALL have port stop_det  in  1  one-cycle pulse: STOP detected.
REQ-010 SHALL have ports sample_x, sample_y, sample_z  in  16 each  live sensor samples.
REQ-011 SHALL have port sample_stb  in  1  one-cycle pulse: the samples are valid.
REQ-012 SHALL have port tx_data  out  8  read byte for the PHY.
REQ-013 SHALL have port tx_valid  out  1  one-cycle pulse qualifying tx_data.
REQ-014 SHALL have port rx_ack  out  1  ACK decision for the last rx byte (1 = ACK); valid with rx_ack_valid.
REQ-015 SHALL have port rx_ack_valid  out  1  one-cycle pulse.
REQ-016 SHALL have port busy  out  1  high while state != IDLE.
REQ-017 SHALL have port pwr_reg  out  8  PWR_MGMT register contents.
REQ-018 SHALL have port wr_err  out  1  one-cycle pulse on a write to a read-only or unmapped address.

Function
REQ-019 SHALL implement the register map: 0x3B..0x40 = X_H, X_L, Y_H, Y_L, Z_H, Z_L (read-only, from the shadow); 0x6B = PWR_MGMT (read/write); 0x75 = WHO_AM_I (read-only, reads 0x68); all other addresses read 0x00.
REQ-020 SHALL use a state machine with states IDLE, GET_PTR, WR_DATA and RD_DATA.
REQ-021 SHALL transition from any state on hdr_valid (repeated START included): hdr_rw=0 -> GET_PTR; hdr_rw=1 -> RD_DATA.
REQ-022 SHALL handle GET_PTR: on rx_valid, ptr <= rx_data, ACK, -> WR_DATA.
REQ-023 SHALL handle WR_DATA: on rx_valid, if ptr==0x6B then pwr_reg <= rx_data and ACK; otherwise no write, NACK, and wr_err pulse; ptr increments in both cases.
REQ-024 SHALL handle RD_DATA: on tx_req, drive tx_data = byte at ptr with tx_valid exactly 1 cycle later; ptr increments on the same cycle as tx_valid.
REQ-025 SHALL handle master_nack in RD_DATA: stay in RD_DATA with no ptr change; any further tx_req is still served.
REQ-026 SHALL transition to IDLE from any state on stop_det.
REQ-027 SHALL keep ptr across transactions (not cleared by STOP); ptr is 8-bit and wraps 0xFF -> 0x00.
REQ-028 SHALL assert rx_ack_valid exactly 1 cycle after every rx_valid in GET_PTR or WR_DATA; rx_valid in IDLE or RD_DATA is ignored with no ACK pulse.
REQ-029 SHALL handle simultaneous events as follows:
- rx_valid with stop_det: the byte is processed, then -> IDLE.
- hdr_valid with stop_det: hdr_valid wins.
- tx_req with stop_det: the byte is still delivered, then -> IDLE.
REQ-030 SHALL capture sample_x/y/z into staging registers on every sample_stb.
REQ-031 SHALL copy staging into the shadow on sample_stb when state != RD_DATA.
REQ-032 SHALL freeze the shadow for the whole read transaction when sample_stb arrives in RD_DATA: set a pending flag and copy the latest staging values on the first cycle after leaving RD_DATA.

Reset
REQ-033 SHALL, on arstn low:
- state = IDLE, ptr = 0x00;
- tx_data = 0x00; tx_valid, rx_ack, rx_ack_valid, wr_err, busy = 0;
- pwr_reg = 0x40;
- staging, shadow and pending = 0.
REQ-034 SHALL treat reset mid-transaction as abandoning it; no output pulse is generated on reset release.

Structure
REQ-035 SHALL place the register addresses (0x3B..0x40, 0x6B, 0x75), WHO_AM_I value 0x68, PWR_MGMT reset 0x40 and the state encoding in the shared package i2c_app_pkg.
REQ-036 SHALL place the snapshot logic (staging, shadow, pending) in one sub-module, sensor_snapshot; the FSM and register decode stay in the top.

Verification
REQ-037 SHALL cover a burst read:
- stimulus: sample_stb with X=0x1234, Y=0xABCD, Z=0x0F0F; write ptr 0x3B; repeated START read; 6 tx_req.
- response: tx_data 12,34,AB,CD,0F,0F, each 1 cycle after its tx_req; final ptr = 0x41.
REQ-038 SHALL cover PWR_MGMT write: ptr 0x6B, data 0x00 -> rx_ack=1 twice, pwr_reg=0x00, ptr=0x6C.
REQ-039 SHALL cover a read-only write: ptr 0x75, data 0x55 -> second rx_ack=0, wr_err pulse, then a read at 0x75 returns 0x68.
REQ-040 SHALL cover coherency: sample_stb X=0x1111 between the 1st and 2nd tx_req of an X_H/X_L read -> both bytes come from the old sample; after STOP, a read returns 0x11,0x11.
REQ-041 SHALL cover wrap: ptr 0xFF, 2 tx_req -> 0x00, 0x00, final ptr = 0x01.
REQ-042 SHALL cover mid-operation reset: arstn low during RD_DATA -> state IDLE, pwr_reg=0x40, ptr=0x00, no tx_valid afterwards.
